// File: rtl/vedic_pkg.sv
// vedic_pkg -- shared definitions for the sequential 8x8 Vedic multiplier.
//   OP_W   : operand width (8)
//   HALF_W : nibble width fed to the 4x4 core (4)
//   PROD_W : product / accumulator width (16)
//   state_e: control FSM states IDLE, MUL, DONE
package vedic_pkg;

  localparam int OP_W   = 8;
  localparam int HALF_W = 4;
  localparam int PROD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vedic_4x4.sv
// vedic_4x4 -- combinational 4x4 unsigned Vedic (Urdhva Tiryagbhyam) multiplier
// built from four vedic_2x2 cells.
//   a, b : 4-bit operands
//   p    : 8-bit product a*b
//
// vedic_2x2 -- 2x2 Vedic cell: vertical and crosswise products with a single
// half-adder chain.
//   a, b : 2-bit operands
//   p    : 4-bit product a*b

module vedic_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);

  logic cross_c;

  assign cross_c = (a[1] & b[0]) & (a[0] & b[1]);
  assign p[0]    = a[0] & b[0];
  assign p[1]    = (a[1] & b[0]) ^ (a[0] & b[1]);
  assign p[2]    = (a[1] & b[1]) ^ cross_c;
  assign p[3]    = (a[1] & b[1]) & cross_c;

endmodule

module vedic_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] q_ll;  // aL*bL
  logic [3:0] q_hl;  // aH*bL
  logic [3:0] q_lh;  // aL*bH
  logic [3:0] q_hh;  // aH*bH

  vedic_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .p(q_ll));
  vedic_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .p(q_hl));
  vedic_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .p(q_lh));
  vedic_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .p(q_hh));

  // Crosswise terms carry weight 4, the high-high term weight 16; max 225 fits.
  assign p = {4'h0, q_ll}
           + {2'b00, q_hl, 2'b00}
           + {2'b00, q_lh, 2'b00}
           + {q_hh, 4'h0};

endmodule

// File: rtl/vedic_8x8_seq.sv
// vedic_8x8_seq -- sequential 8x8 unsigned multiplier that time-shares one
// combinational vedic_4x4 core over four nibble partial products.
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operands on a/b valid
//   in_ready  : high in IDLE only
//   a, b      : 8-bit operands, latched on accept
//   out_valid : p holds a completed product (DONE)
//   out_ready : consumer accepts p
//   p         : registered 16-bit product, held after the handshake
//   busy      : high in MUL or DONE
// Accept edge -> 4 MUL edges (last one writes p) -> DONE until out_ready.

import vedic_pkg::*;

module vedic_8x8_seq (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   p,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [OP_W-1:0]     a_q, b_q;
  logic [PROD_W-1:0]   acc_q;
  logic [PROD_W-1:0]   p_q;
  logic [1:0]          step_q;

  logic [HALF_W-1:0]   a_nib, b_nib;
  logic [OP_W-1:0]     pp;
  logic [PROD_W-1:0]   pp_shift;
  logic [PROD_W-1:0]   acc_sum;

  // step[0] selects the a nibble, step[1] the b nibble, giving the order
  // aL*bL, aH*bL, aL*bH, aH*bH.
  assign a_nib = step_q[0] ? a_q[OP_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign b_nib = step_q[1] ? b_q[OP_W-1:HALF_W] : b_q[HALF_W-1:0];

  vedic_4x4 u_core (.a(a_nib), .b(b_nib), .p(pp));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pp_shift = {8'h00, pp};
    case (step_q)
      2'd1, 2'd2: pp_shift = {4'h0, pp, 4'h0};
      2'd3:       pp_shift = {pp, 8'h00};
      default:    pp_shift = {8'h00, pp};
    endcase
  end

  // Cannot overflow: the largest final sum is 0xFE01.
  assign acc_sum = acc_q + pp_shift;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)       state_d = MUL;
      MUL:     if (step_q == 2'd3) state_d = DONE;
      DONE:    if (out_ready)      state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      p_q    <= '0;
      step_q <= 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q    <= a;
            b_q    <= b;
            acc_q  <= '0;
            step_q <= 2'd0;
          end
        end
        MUL: begin
          acc_q  <= acc_sum;
          step_q <= step_q + 2'd1;
          if (step_q == 2'd3) p_q <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL) || (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_vedic_8x8_seq.sv
// tb_vedic_8x8_seq -- directed + randomized self-checking bench for
// vedic_8x8_seq. Reference model is plain a*b arithmetic plus the handshake
// timing rules (4-edge latency, 6-cycle issue interval).

module tb_vedic_8x8_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vedic_8x8_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .p        (p),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  function automatic logic [15:0] model_mul(input logic [7:0] x, input logic [7:0] y);
    return 16'(int'(x) * int'(y));
  endfunction

  // One complete operation: accept, wait for result, hold out_ready low for
  // 'hold' cycles, then handshake. With 'junk' set, in_valid stays high and
  // a/b are scrambled while busy; none of that may leak into the result.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] ib,
                       input int hold, input bit junk);
    logic [15:0] exp;
    int lat;
    exp = model_mul(ia, ib);
    check("pre_in_ready", 32'(in_ready), 32'd1);
    check("pre_busy", 32'(busy), 32'd0);
    a = ia; b = ib; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;  // accept edge
    if (junk) begin a = 8'($urandom); b = 8'($urandom); end
    else in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("mul_busy", 32'(busy), 32'd1);
      check("mul_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
      if (junk) begin a = 8'($urandom); b = 8'($urandom); end
    end
    check("latency", 32'(lat), 32'd4);
    for (int i = 0; i < hold; i++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_p", 32'(p), 32'(exp));
      @(posedge clk); #1;
      if (junk) begin a = 8'($urandom); b = 8'($urandom); end
    end
    check("done_valid", 32'(out_valid), 32'd1);
    check("done_p", 32'(p), 32'(exp));
    out_ready = 1'b1;
    @(posedge clk); #1;  // handshake edge
    out_ready = 1'b0;
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_busy", 32'(busy), 32'd0);
    check("post_p_kept", 32'(p), 32'(exp));
    in_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] exp;
    int last;
    int n_acc;

    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; a = 8'hFF; b = 8'hFF;
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_p", 32'(p), 32'h0);
    @(posedge clk); #1;
    check("rst_hold_busy", 32'(busy), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Accept on the first edge after reset release.
    do_op(8'h00, 8'h00, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 0, 1'b0);
    do_op(8'h0F, 8'hF0, 0, 1'b0);
    do_op(8'hA5, 8'h3C, 1, 1'b0);
    do_op(8'h12, 8'h34, 3, 1'b0);
    // Busy-time operands ignored; in_valid high through the DONE handshake.
    do_op(8'h0F, 8'hF0, 2, 1'b1);
    do_op(8'hFF, 8'hFF, 0, 1'b0);

    // Reset during step 2 aborts the operation.
    a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;  // accept
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;  // step 2 pending
    rst_n = 1'b0;
    #1;
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_p", 32'(p), 32'h0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    do_op(8'h03, 8'h03, 0, 1'b0);

    for (int i = 0; i < 8; i++)
      do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    // Back-to-back issue with out_ready held high.
    last = -1; n_acc = 0;
    out_ready = 1'b1;
    a = 8'($urandom); b = 8'($urandom);
    for (int i = 0; i < 50; i++) begin
      bit accepted;
      in_valid = (i < 37);
      accepted = in_valid && in_ready;
      if (accepted) begin
        q.push_back(model_mul(a, b));
        if (last >= 0) check("issue_gap", 32'(i - last), 32'd6);
        last = i;
        n_acc++;
      end
      if (out_valid) begin
        exp = (q.size() > 0) ? q.pop_front() : 16'hxxxx;
        check("b2b_p", 32'(p), 32'(exp));
      end
      @(posedge clk); #1;
      if (accepted) begin a = 8'($urandom); b = 8'($urandom); end
    end
    check("b2b_accepts", 32'(n_acc), 32'd7);
    check("b2b_drained", 32'(q.size()), 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vedic_8x8_seq.md
VEDIC_8X8_SEQ -- requirements
Module: vedic_8x8_seq

Interface
REQ-001 The block SHALL have no parameters; operand width SHALL be fixed at 8 bits and product width at 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  8  multiplicand.
REQ-007 b  input  8  multiplier.
REQ-008 out_valid  output  1  p holds a completed product.
REQ-009 out_ready  input  1  consumer accepts p.
REQ-010 p  output  16  registered product a*b, unsigned.
REQ-011 busy  output  1  high in MUL or DONE.

Function
REQ-012 The block SHALL time-share one combinational 4x4 Vedic multiplier across four partial products per operation.
REQ-013 The FSM SHALL have the states IDLE, MUL and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; an accept SHALL occur on an edge where in_valid and in_ready are both 1.
REQ-015 On accept, the block SHALL latch a and b, clear the 16-bit accumulator, set step to 0 and enter MUL.
REQ-016 In MUL, each edge SHALL add one partial product to the accumulator and increment the 2-bit step.
REQ-017 The partial products SHALL be applied in fixed order: step0 aL*bL shifted 0, step1 aH*bL shifted 4, step2 aL*bH shifted 4, step3 aH*bH shifted 8.
REQ-018 On the step-3 edge, the block SHALL write the final sum to p, set out_valid to 1 and enter DONE.
REQ-019 Latency SHALL be exactly 4 cycles from the accept edge to the edge that asserts out_valid.
REQ-020 The accumulator SHALL be 16 bits and SHALL never overflow, since the maximum product is 0xFE01.
REQ-021 In DONE, out_valid and p SHALL stay stable until out_ready is 1.
REQ-022 When out_valid and out_ready are both 1, out_valid SHALL clear and the FSM SHALL return to IDLE on that edge.
REQ-023 p SHALL retain its last value after out_valid falls.
REQ-024 While busy, in_valid, a and b SHALL be ignored; changes to a or b after accept SHALL NOT affect the result.
REQ-025 When in_valid is 1 in DONE at the same time as the out_ready handshake, the operands SHALL NOT be accepted until the following cycle in IDLE.
REQ-026 Minimum issue interval SHALL therefore be 6 cycles per operation.
REQ-027 A zero operand SHALL still take the full 4 MUL cycles; there SHALL be no early termination.

Reset
REQ-028 While rst_n is 0: state SHALL be IDLE, step 0, accumulator 0, p 16'h0000, out_valid 0, busy 0 and in_ready 1.
REQ-029 Reset asserted mid-operation SHALL abort the operation immediately; no out_valid SHALL be produced for the aborted operands.
REQ-030 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Structure
REQ-031 Package vedic_pkg SHALL hold the FSM state enum (IDLE, MUL, DONE) and the constants OP_W=8, HALF_W=4 and PROD_W=16.
REQ-032 The block SHALL contain exactly one sub-module instance, vedic_4x4, a combinational 4x4 Vedic multiplier built from vedic_2x2 cells.
REQ-033 Operand nibble selection SHALL be done by muxes driven by step.
REQ-034 The shift and add logic SHALL live in vedic_8x8_seq.

Verification
REQ-035 Scenario: a=0x00, b=0x00, out_ready=1 -> out_valid on the 4th edge after accept, p=0x0000, in_ready=1 one cycle later.
REQ-036 Scenario: a=0xFF, b=0xFF -> p=0xFE01.
REQ-036a Scenario: a=0x0F, b=0xF0 -> p=0x0E10.
REQ-036b Scenario: a=0xA5, b=0x3C -> p=0x26AC.
REQ-037 Scenario: a=0x12, b=0x34 with out_ready held 0 for 3 cycles after out_valid -> out_valid and p=0x03A8 stable throughout; return to IDLE on the edge where out_ready=1.
REQ-038 Scenario: accept a=0x0F, b=0xF0, then drive a=0xFF, b=0xFF with in_valid=1 while busy -> result p=0x0E10 only; 0xFF*0xFF is accepted only after return to IDLE and yields 0xFE01.
REQ-039 Scenario: rst_n pulsed low during step 2 of a=0xFF, b=0xFF -> out_valid stays 0, p=0x0000 and in_ready=1; a following a=0x03, b=0x03 gives p=0x0009.
REQ-040 Scenario: back-to-back in_valid with out_ready=1 -> accepts SHALL occur exactly every 6 cycles.
